// File: rtl/mac_rmii_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_rmii_tx : store-and-forward Ethernet MAC transmitter with RMII output  |
// | Optional minimum-length padding enabled by macro MAC_TX_PAD_EN.            |
// | Revision 1.0 - initial release                                             |
// +--------------------------------------------------------------------------+
module mac_rmii_tx #(
  parameter int BUF_AW   = 11,
  parameter int IFG_CLKS = 48
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_mac_tx_sop,
  input  logic       i_mac_tx_eop,
  input  logic       i_mac_tx_vld,
  input  logic [7:0] i_mac_tx_dat,
  output logic       o_mac_tx_rdy,
  output logic       o_rmii_tx_vld,
  output logic [1:0] o_rmii_tx_dat,
  output logic       o_tx_done
);

  localparam int              PW         = BUF_AW + 1;
  localparam int              DEPTH      = 1 << BUF_AW;
  localparam logic [PW-1:0]   PTR_ONE    = 1;
  localparam logic [6:0]      MIN_LEN    = 7'd60;
  localparam logic [31:0]     CRC_POLY_R = 32'hEDB8_8320;
  localparam logic [31:0]     CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [15:0]     IFG_LAST   = 16'(IFG_CLKS - 1);
`ifdef MAC_TX_PAD_EN
  localparam bit              PAD_EN     = 1'b1;
`else
  localparam bit              PAD_EN     = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DATA     = 3'd2,
    S_PAD      = 3'd3,
    S_FCS      = 3'd4,
    S_IFG      = 3'd5
  } state_t;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- buffer
  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] start_q, start_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          in_frame_q, in_frame_d;
  logic          bad_q, bad_d;
  logic          rdy_en_q;
  logic          w_full;
  logic          w_we;
  logic [PW-1:0] w_waddr;
  logic          w_commit;
  logic          w_ok;
  logic          w_dec;
  logic [8:0]    w_rd_word;

  assign w_full       = (wr_ptr_q[BUF_AW] != rd_ptr_q[BUF_AW]) &&
                        (wr_ptr_q[BUF_AW-1:0] == rd_ptr_q[BUF_AW-1:0]);
  assign o_mac_tx_rdy = rdy_en_q & ~w_full;
  assign w_rd_word    = mem_q[rd_ptr_q[BUF_AW-1:0]];

  // A frame only becomes visible to the reader once its eop is stored;
  // bad or restarted frames rewind to start_q, which always marks the
  // first free entry after the last committed frame.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    start_d    = start_q;
    in_frame_d = in_frame_q;
    bad_d      = bad_q;
    w_we       = 1'b0;
    w_waddr    = wr_ptr_q;
    w_commit   = 1'b0;
    w_ok       = 1'b0;
    if (i_mac_tx_vld) begin
      if (i_mac_tx_sop) begin
        w_ok    = o_mac_tx_rdy;
        w_we    = w_ok;
        w_waddr = start_q;
        if (i_mac_tx_eop) begin
          in_frame_d = 1'b0;
          bad_d      = 1'b0;
          if (w_ok) begin
            wr_ptr_d = start_q + PTR_ONE;
            start_d  = start_q + PTR_ONE;
            w_commit = 1'b1;
          end else begin
            wr_ptr_d = start_q;
          end
        end else begin
          in_frame_d = 1'b1;
          bad_d      = ~w_ok;
          wr_ptr_d   = w_ok ? (start_q + PTR_ONE) : start_q;
        end
      end else if (in_frame_q) begin
        w_ok    = o_mac_tx_rdy & ~bad_q;
        w_we    = w_ok;
        w_waddr = wr_ptr_q;
        if (i_mac_tx_eop) begin
          in_frame_d = 1'b0;
          bad_d      = 1'b0;
          if (w_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            start_d  = wr_ptr_q + PTR_ONE;
            w_commit = 1'b1;
          end else begin
            wr_ptr_d = start_q;
          end
        end else if (w_ok) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
          bad_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case ({w_commit, w_dec})
      2'b10:   cnt_d = cnt_q + PTR_ONE;
      2'b01:   cnt_d = cnt_q - PTR_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      mem_q[w_waddr[BUF_AW-1:0]] <= {i_mac_tx_eop, i_mac_tx_dat};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      start_q    <= '0;
      cnt_q      <= '0;
      in_frame_q <= 1'b0;
      bad_q      <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      in_frame_q <= in_frame_d;
      bad_q      <= bad_d;
      rdy_en_q   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  sub_q, sub_d;
  logic [6:0]  len_q, len_d;
  logic [15:0] ifg_q, ifg_d;
  logic [31:0] crc_q, crc_d;
  logic [6:0]  w_len_nx;
  logic [31:0] w_fcs;
  logic [7:0]  w_byte;
  logic [1:0]  w_dibit;
  logic        w_active;
  logic        w_done;
  logic        rmii_vld_q;
  logic [1:0]  rmii_dat_q;
  logic        done_q;

  assign w_len_nx = (len_q == 7'h7F) ? len_q : (len_q + 7'd1);
  assign w_fcs    = ~crc_q;
  assign w_dibit  = w_byte[{phase_q, 1'b0} +: 2];

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    sub_d    = sub_q;
    len_d    = len_q;
    ifg_d    = ifg_q;
    crc_d    = crc_q;
    rd_ptr_d = rd_ptr_q;
    w_dec    = 1'b0;
    w_byte   = 8'h00;
    w_active = 1'b0;
    w_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        phase_d = 2'd0;
        sub_d   = 3'd0;
        if (cnt_q != '0) state_d = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        w_active = 1'b1;
        w_byte   = (sub_q == 3'd7) ? 8'hD5 : 8'h55;
        crc_d    = CRC_INIT;
        len_d    = 7'd0;
        phase_d  = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          sub_d = sub_q + 3'd1;
          if (sub_q == 3'd7) state_d = S_DATA;
        end
      end
      S_DATA: begin
        w_active = 1'b1;
        w_byte   = w_rd_word[7:0];
        phase_d  = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          crc_d    = crc_byte(crc_q, w_byte);
          len_d    = w_len_nx;
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          if (w_rd_word[8]) begin
            w_dec   = 1'b1;
            state_d = (PAD_EN && (w_len_nx < MIN_LEN)) ? S_PAD : S_FCS;
          end
        end
      end
      S_PAD: begin
        w_active = 1'b1;
        phase_d  = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          crc_d = crc_byte(crc_q, 8'h00);
          len_d = w_len_nx;
          if (w_len_nx >= MIN_LEN) state_d = S_FCS;
        end
      end
      S_FCS: begin
        w_active = 1'b1;
        w_byte   = w_fcs[{sub_q[1:0], 3'b000} +: 8];
        phase_d  = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (sub_q == 3'd3) begin
            w_done  = 1'b1;
            sub_d   = 3'd0;
            ifg_d   = 16'd0;
            state_d = S_IFG;
          end else begin
            sub_d = sub_q + 3'd1;
          end
        end
      end
      S_IFG: begin
        phase_d = 2'd0;
        // Skipping IDLE keeps back-to-back gaps at exactly IFG_CLKS.
        if (ifg_q == IFG_LAST) begin
          ifg_d   = 16'd0;
          state_d = (cnt_q != '0) ? S_PREAMBLE : S_IDLE;
        end else begin
          ifg_d = ifg_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 2'd0;
      sub_q      <= 3'd0;
      len_q      <= 7'd0;
      ifg_q      <= 16'd0;
      crc_q      <= 32'd0;
      rd_ptr_q   <= '0;
      rmii_vld_q <= 1'b0;
      rmii_dat_q <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      sub_q      <= sub_d;
      len_q      <= len_d;
      ifg_q      <= ifg_d;
      crc_q      <= crc_d;
      rd_ptr_q   <= rd_ptr_d;
      rmii_vld_q <= w_active;
      rmii_dat_q <= w_active ? w_dibit : 2'b00;
      done_q     <= w_done;
    end
  end

  assign o_rmii_tx_vld = rmii_vld_q;
  assign o_rmii_tx_dat = rmii_dat_q;
  assign o_tx_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_rmii_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mac_rmii_tx : scoreboard bench for mac_rmii_tx (MAC_TX_PAD_EN aware)    |
// | Revision 1.0 - initial release                                             |
// +--------------------------------------------------------------------------+
module tb_mac_rmii_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sop = 1'b0, eop = 1'b0, vld = 1'b0;
  logic [7:0] dat = 8'h00;
  logic       rdy, tx_vld, tx_done;
  logic [1:0] tx_dat;

  always #10 clk = ~clk;

  mac_rmii_tx #(.BUF_AW(11), .IFG_CLKS(48)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_mac_tx_sop  (sop),
    .i_mac_tx_eop  (eop),
    .i_mac_tx_vld  (vld),
    .i_mac_tx_dat  (dat),
    .o_mac_tx_rdy  (rdy),
    .o_rmii_tx_vld (tx_vld),
    .o_rmii_tx_dat (tx_dat),
    .o_tx_done     (tx_done)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ d[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB8_8320;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  // Scoreboard: flat byte stream plus per-frame length
  logic [7:0] exp_b_q[$];
  int         exp_len_q[$];

  // ---------------------------------------------------------------- monitor
  logic [1:0] cap_q[$];
  bit         prev_vld = 1'b0;
  bit         aborted = 1'b0;
  int         done_cnt = 0, done_idx = -1;
  int         frames_seen = 0;
  int         idle_cnt = 0, last_gap = -1;
  int         last_dibits = 0, last_wire = 0;

  task automatic finish_frame();
    logic [7:0]  by[$];
    logic [7:0]  e;
    logic [31:0] c;
    int          nb, len, mism;
    bit          pre_ok;
    if (aborted) begin
      cap_q.delete();
      return;
    end
    frames_seen++;
    last_dibits = cap_q.size();
    nb = cap_q.size() / 4;
    last_wire = nb - 8;
    for (int k = 0; k < nb; k++)
      by.push_back({cap_q[4*k+3], cap_q[4*k+2], cap_q[4*k+1], cap_q[4*k]});
    if (exp_len_q.size() == 0) begin
      chk("unexpected_frame", 64'(cap_q.size()), 64'd0);
      cap_q.delete();
      return;
    end
    len = exp_len_q.pop_front();
    chk("frame_dibits", 64'(cap_q.size()), 64'(4 * (8 + len)));
    pre_ok = (nb >= 8);
    for (int k = 0; k < 8 && k < nb; k++)
      if (by[k] !== ((k == 7) ? 8'hD5 : 8'h55)) pre_ok = 1'b0;
    chk("preamble_sfd", 64'(pre_ok), 64'd1);
    mism = 0;
    for (int k = 0; k < len; k++) begin
      e = exp_b_q.pop_front();
      if ((8 + k >= nb) || (by[8+k] !== e)) mism++;
    end
    chk("frame_bytes", 64'(mism), 64'd0);
    c = 32'hFFFF_FFFF;
    for (int k = 8; k < nb; k++) c = crc_step(c, by[k]);
    chk("crc_residue", 64'(c), 64'hDEBB_20E3);
    chk("tx_done_count", 64'(done_cnt), 64'd1);
    chk("tx_done_pos", 64'(done_idx), 64'(cap_q.size() - 1));
    cap_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst_n && (tx_vld || prev_vld)) aborted = 1'b1;
    if (tx_vld) begin
      if (!prev_vld) begin
        last_gap = idle_cnt;
        cap_q.delete();
        done_cnt = 0;
        done_idx = -1;
        aborted  = 1'b0;
      end
      cap_q.push_back(tx_dat);
      if (tx_done) begin
        done_cnt++;
        done_idx = cap_q.size() - 1;
      end
      idle_cnt = 0;
    end else begin
      if (prev_vld) finish_frame();
      if (tx_done) chk("done_while_idle", 64'(tx_done), 64'd0);
      idle_cnt++;
    end
    prev_vld = tx_vld;
  end

  // ---------------------------------------------------------------- stimulus
  bit saw_rdy_low = 1'b0;

  // kind: 0 all-zero, 1 ramp, 2 random
  task automatic send_frame(input int len, input int kind, input bit expect_tx);
    logic [7:0]  exp[$];
    logic [7:0]  b;
    logic [31:0] c;
    for (int i = 0; i < len; i++) begin
      b   = (kind == 0) ? 8'h00 : (kind == 1) ? 8'(i * 7 + 3) : 8'($urandom);
      exp.push_back(b);
      sop = (i == 0);
      eop = (i == len - 1);
      vld = 1'b1;
      dat = b;
      if (!rdy) saw_rdy_low = 1'b1;
      if (i == len - 1 && expect_tx) begin
`ifdef MAC_TX_PAD_EN
        while (exp.size() < 60) exp.push_back(8'h00);
`endif
        c = 32'hFFFF_FFFF;
        foreach (exp[k]) c = crc_step(c, exp[k]);
        c = ~c;
        for (int k = 0; k < 4; k++) exp.push_back(c[8*k +: 8]);
        exp_len_q.push_back(exp.size());
        foreach (exp[k]) exp_b_q.push_back(exp[k]);
      end
      @(posedge clk); #1;
    end
    vld = 1'b0;
    sop = 1'b0;
    eop = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 6000; i++) begin
      if (frames_seen >= n) break;
      @(posedge clk); #1;
    end
    chk("frame_arrived", 64'(frames_seen >= n), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 64'(tx_vld), 64'd0);
    chk("rst_dat", 64'(tx_dat), 64'd0);
    chk("rst_done", 64'(tx_done), 64'd0);
    chk("rst_rdy", 64'(rdy), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_clk", 64'(rdy), 64'd0);
    @(posedge clk); #1;
    chk("rdy_after_release", 64'(rdy), 64'd1);

    // 60-byte all-zero frame; first dibit two clocks after the eop write
    send_frame(60, 0, 1'b1);
    @(posedge clk); #1;
    chk("latency_clk1", 64'(tx_vld), 64'd0);
    @(posedge clk); #1;
    chk("latency_clk2", 64'(tx_vld), 64'd1);
    wait_frames(1);
    chk("len60_dibits", 64'(last_dibits), 64'd288);

    send_frame(14, 1, 1'b1);
    wait_frames(2);
`ifdef MAC_TX_PAD_EN
    chk("short_wire_len", 64'(last_wire), 64'd64);
`else
    chk("short_wire_len", 64'(last_wire), 64'd18);
`endif
    chk("ifg_min", 64'(last_gap >= 48), 64'd1);

    send_frame(1, 2, 1'b1);
    wait_frames(3);

    // Bytes before any sop are ignored
    vld = 1'b1; dat = 8'hAA;
    repeat (3) begin @(posedge clk); #1; end
    vld = 1'b0;
    send_frame(20, 2, 1'b1);
    wait_frames(4);

    // Frame restarted by a fresh sop before its eop
    for (int i = 0; i < 5; i++) begin
      sop = (i == 0); vld = 1'b1; dat = 8'hE0 + 8'(i);
      @(posedge clk); #1;
    end
    send_frame(30, 2, 1'b1);
    wait_frames(5);

    // Back-to-back frames
    send_frame(100, 2, 1'b1);
    send_frame(100, 1, 1'b1);
    wait_frames(7);
    chk("b2b_gap", 64'(last_gap), 64'd48);

    // Overflow: oversized frame must be discarded
    saw_rdy_low = 1'b0;
    send_frame(2100, 2, 1'b0);
    chk("ovf_rdy_fell", 64'(saw_rdy_low), 64'd1);
    chk("ovf_rdy_back", 64'(rdy), 64'd1);
    send_frame(64, 2, 1'b1);
    wait_frames(8);
    repeat (100) @(posedge clk);
    #1;
    chk("ovf_frame_count", 64'(frames_seen), 64'd8);

    // Reset during transmission discards everything buffered
    send_frame(60, 1, 1'b0);
    send_frame(20, 2, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (tx_vld && cap_q.size() >= 100) break;
      @(posedge clk); #1;
    end
    chk("rst_reached_dibit100", 64'(cap_q.size() >= 100), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_vld_async", 64'(tx_vld), 64'd0);
    chk("rst_dat_async", 64'(tx_dat), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_rdy_held", 64'(rdy), 64'd0);
    @(posedge clk); #1;
    chk("rst_rdy_rise", 64'(rdy), 64'd1);
    repeat (1200) @(posedge clk);
    #1;
    chk("no_residual_frame", 64'(frames_seen), 64'd8);

    send_frame(40, 2, 1'b1);
    wait_frames(9);
    chk("scoreboard_empty", 64'(exp_len_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_rmii_tx.md
MAC_RMII_TX -- requirements
Module: mac_rmii_tx

Interface
REQ-001 Parameter BUF_AW, default 11: frame buffer address width; buffer holds 2^BUF_AW entries of 9 bits (data byte plus eop flag).
REQ-002 Parameter IFG_CLKS, default 48: idle clocks between frames (12 byte times at 4 clocks per byte).
REQ-003 i_clk  in  1  50 MHz RMII reference clock; all logic is on its rising edge.
REQ-004 i_rst_n  in  1  asynchronous active-low reset.
REQ-005 i_mac_tx_sop  in  1  first byte of frame (destination MAC byte 0).
REQ-006 i_mac_tx_eop  in  1  last byte of frame.
REQ-007 i_mac_tx_vld  in  1  byte qualifier; at most one byte per clock, any rate.
REQ-008 i_mac_tx_dat  in  8  frame byte; upstream supplies header and payload only, with no preamble and no FCS.
REQ-009 o_mac_tx_rdy  out  1  buffer has at least 1 free entry.
REQ-010 o_rmii_tx_vld  out  1  RMII TX_EN.
REQ-011 o_rmii_tx_dat  out  2  RMII TXD[1:0].
REQ-012 o_tx_done  out  1  one-clock pulse on the last FCS dibit.

Function
REQ-013 Operation SHALL be store-and-forward: a frame is eligible for transmission only after its eop byte is written; a completed-frame counter SHALL track eligible frames.
REQ-014 Write side: a byte SHALL be written when vld=1 and rdy=1; the eop flag SHALL be stored with the byte.
REQ-015 vld=1 while rdy=0 is overflow: the byte SHALL be dropped, the frame marked bad, and on its eop the write pointer SHALL rewind to the frame start, discarding the frame.
REQ-016 sop received mid-frame: the write pointer SHALL rewind to the old frame start and the new frame starts there.
REQ-017 Bytes with vld=1 before any sop SHALL be dropped.
REQ-018 A 1-byte frame (sop=eop=1 in the same cycle) SHALL be valid.
REQ-019 TX FSM states: IDLE, PREAMBLE, DATA, PAD, FCS, IFG.
REQ-020 IDLE -> PREAMBLE when the frame counter is nonzero; the first preamble dibit SHALL appear 2 clocks after the eop write when the FSM is idle.
REQ-021 PREAMBLE SHALL send 7 x 0x55 then SFD 0xD5 (32 dibits).
REQ-022 DATA SHALL send buffered bytes; DATA -> PAD after the eop byte if the byte count is less than 60; otherwise DATA -> FCS.
REQ-023 PAD SHALL send 0x00 bytes until the byte count reaches 60, then -> FCS.
REQ-024 FCS SHALL send 4 bytes, then -> IFG.
REQ-025 IFG SHALL hold vld low for IFG_CLKS clocks, then -> IDLE; frame-count decrement SHALL occur on DATA exit.
REQ-026 Each byte SHALL occupy exactly 4 consecutive clocks, dibit order [1:0], [3:2], [5:4], [7:6]; o_rmii_tx_vld SHALL be continuously 1 from the first preamble dibit to the last FCS dibit.
REQ-027 CRC SHALL be CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over DATA and PAD bytes; the FCS SHALL be the complemented register, low byte first.
REQ-028 A simultaneous counter increment (write eop) and decrement (DATA exit) SHALL leave the count unchanged; simultaneous buffer read and write SHALL be legal.
REQ-029 rdy SHALL be combinational on buffer full; the pointers SHALL be BUF_AW+1 bits with wrap-around.

Reset
REQ-030 During reset: o_rmii_tx_vld=0, o_rmii_tx_dat=0, o_tx_done=0, o_mac_tx_rdy=0; FSM=IDLE; pointers, counters and CRC cleared.
REQ-031 o_mac_tx_rdy SHALL rise on the first clock after reset release.
REQ-032 Reset mid-frame SHALL drop o_rmii_tx_vld asynchronously and discard all buffered frames.

Configuration
REQ-033 Macro MAC_TX_PAD_EN defined: the PAD state applies (60-byte minimum before FCS).
REQ-034 Macro MAC_TX_PAD_EN undefined: PAD is absent, DATA -> FCS always, and short frames are sent unpadded.

Verification
REQ-035 60-byte frame, vld every clock -> 32 preamble/SFD dibits, 240 data dibits, 16 FCS dibits, o_tx_done on the last FCS dibit, then 48 idle clocks.
REQ-036 Any frame captured from the RMII output -> CRC register over data+FCS ends at residue 0xDEBB20E3; the FCS for a 60-byte all-zero frame equals 0x76 0x1D 0xB4 0x9D... recomputed by the bench model.
REQ-037 14-byte frame, MAC_TX_PAD_EN defined -> 46 0x00 pad bytes, 64 bytes on wire after SFD; macro undefined -> 18 bytes after SFD.
REQ-038 Two back-to-back 100-byte frames written in 200 clocks -> two frames sent, separated by exactly 48 clocks of vld=0.
REQ-039 Overflow: a 2100-byte frame with BUF_AW=11 -> rdy falls, the frame is discarded, and the next 64-byte frame is transmitted intact.
REQ-040 i_rst_n asserted at dibit 100 of a frame -> vld=0 immediately; after release no residual frame is sent and rdy=1 one clock later.
